// File: rtl/clock_seq_if.sv
// clock_seq_if: status and control signals between the clock sequencer and
// the rest of the design.
//   locked   : DCM lock status (asynchronous to the system clock)
//   modelReq : requested machine model, level (asynchronous)
//   keyReset : one-cycle user reset request (synchronous)
//   model    : clock mux select driven back to the DCM block
//   rstOut   : synchronous active-high core reset
//   ce7M0    : 7 MHz pixel clock-enable strobe
//   ce3M5    : 3.5 MHz CPU clock-enable strobe
// master = environment/stimulus side, slave = sequencer side.
interface clock_seq_if;
  logic locked;
  logic modelReq;
  logic keyReset;
  logic model;
  logic rstOut;
  logic ce7M0;
  logic ce3M5;

  modport master (
    output locked, modelReq, keyReset,
    input  model, rstOut, ce7M0, ce3M5
  );

  modport slave (
    input  locked, modelReq, keyReset,
    output model, rstOut, ce7M0, ce3M5
  );
endinterface

// File: rtl/clock_seq.sv
// clock_seq: clock-domain sequencer on the 56 MHz system clock.
// Watches DCM lock and the requested machine model, drives the clock mux
// select, holds the core in reset across lock loss and model switches, and
// generates the 7 MHz / 3.5 MHz clock-enable strobes.
// Ports:
//   clock56 : system clock (mux output), rising-edge logic
//   reset   : asynchronous active-high reset
//   bus     : clock_seq_if.slave (locked, modelReq, keyReset in;
//             model, rstOut, ce7M0, ce3M5 out)
// Parameters:
//   HOLD  : consecutive locked cycles required before releasing reset
//   DRAIN : reset-asserted cycles before the mux select is toggled
module clock_seq #(
  parameter int HOLD  = 1024,
  parameter int DRAIN = 16
) (
  input logic      clock56,
  input logic      reset,
  clock_seq_if.slave bus
);

  localparam int MAXC = (HOLD > DRAIN) ? HOLD : DRAIN;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD - 1);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN - 1);

  typedef enum logic [1:0] {
    S_WAITLOCK = 2'd0,
    S_RUN      = 2'd1,
    S_DRAIN    = 2'd2,
    S_SWITCH   = 2'd3
  } state_t;

  logic          locked_p0, locked_p1;
  logic          model_p0, model_p1;
  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          model_r, model_nxt;
  logic [3:0]    div, div_nxt;
  logic          rst_r, ce7_r, ce3_r;

  // Next-state logic. One counter serves both the lock hold-off in
  // WAITLOCK and the drain delay in DRAIN; it is cleared on every entry.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    model_nxt = model_r;
    case (state)
      S_WAITLOCK: begin
        if (!locked_p1 || bus.keyReset) begin
          cnt_nxt = '0;
        end else if (cnt == HOLD_LAST) begin
          state_nxt = S_RUN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      S_RUN: begin
        if (!locked_p1 || bus.keyReset) begin
          state_nxt = S_WAITLOCK;
          cnt_nxt   = '0;
        end else if (model_p1 != model_r) begin
          state_nxt = S_DRAIN;
          cnt_nxt   = '0;
        end
      end
      S_DRAIN: begin
        // Lock, keyReset and model requests are deliberately ignored here:
        // once draining starts the switch always completes.
        if (cnt == DRAIN_LAST) begin
          state_nxt = S_SWITCH;
          model_nxt = ~model_r;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      S_SWITCH: begin
        state_nxt = S_WAITLOCK;
        cnt_nxt   = '0;
      end
      default: begin
        state_nxt = S_WAITLOCK;
        cnt_nxt   = '0;
      end
    endcase

    // Divider only advances while staying in RUN, so it restarts from 0
    // every time the core leaves reset.
    if ((state == S_RUN) && (state_nxt == S_RUN)) begin
      div_nxt = div + 4'd1;
    end else begin
      div_nxt = 4'd0;
    end
  end

  always_ff @(posedge clock56 or posedge reset) begin
    if (reset) begin
      locked_p0 <= 1'b0;
      locked_p1 <= 1'b0;
      model_p0  <= 1'b0;
      model_p1  <= 1'b0;
      state     <= S_WAITLOCK;
      cnt       <= '0;
      model_r   <= 1'b0;
      div       <= 4'd0;
      rst_r     <= 1'b1;
      ce7_r     <= 1'b0;
      ce3_r     <= 1'b0;
    end else begin
      // Stage p0 -> p1: two-flop synchronizers for the asynchronous inputs.
      locked_p0 <= bus.locked;
      locked_p1 <= locked_p0;
      model_p0  <= bus.modelReq;
      model_p1  <= model_p0;

      state   <= state_nxt;
      cnt     <= cnt_nxt;
      model_r <= model_nxt;
      div     <= div_nxt;

      // Outputs are registered from the next-state values so that rstOut
      // and the strobes change on the same edge the state enters/leaves RUN.
      rst_r <= (state_nxt != S_RUN);
      ce7_r <= (state_nxt == S_RUN) && (div_nxt[2:0] == 3'd7);
      ce3_r <= (state_nxt == S_RUN) && (div_nxt == 4'd15);
    end
  end

  assign bus.model  = model_r;
  assign bus.rstOut = rst_r;
  assign bus.ce7M0  = ce7_r;
  assign bus.ce3M5  = ce3_r;

endmodule

// File: doc/clock_seq.md
# clock_seq

Clock-domain sequencer on the 56 MHz system clock, sitting directly downstream of the DCM pair and its glitch-free clock mux. It consumes the DCM `locked` status and a requested machine model, drives the mux `model` select, holds the core in reset across lock loss and model switches, and generates the 7 MHz pixel and 3.5 MHz CPU clock-enable strobes for the rest of the design.

## Interface

- `HOLD`, default 1024: consecutive locked cycles required before releasing reset.
- `DRAIN`, default 16: reset-asserted cycles before the mux select is toggled.

- `clock56`  in  1  system clock, the mux output; all logic on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `locked`  in  1  DCM lock status, asynchronous to `clock56`.
- `modelReq`  in  1  requested model, level, asynchronous; 0 = 56.000 MHz, 1 = 56.7504 MHz.
- `keyReset`  in  1  user reset request, one-cycle pulse, synchronous.
- `model`  out  1  mux select driven to the DCM block.
- `rstOut`  out  1  synchronous active-high core reset.
- `ce7M0`  out  1  1-cycle strobe every 8 clocks.
- `ce3M5`  out  1  1-cycle strobe every 16 clocks.

## Operation

- Synchronizers: `locked` and `modelReq` each pass through a 2-flop chain, giving `lockedS` and `modelS`.
- Counters: one hold/drain counter of width ceil(log2(max(HOLD, DRAIN))), and one 4-bit divider `div`.
- States: WAITLOCK, RUN, DRAIN, SWITCH.
- WAITLOCK:
  - Counter clears whenever `lockedS` = 0 or `keyReset` = 1; otherwise it increments.
  - When the counter equals HOLD-1 with `lockedS` = 1 and no `keyReset`, go to RUN.
- RUN transitions, in priority order:
  - `lockedS` = 0 goes to WAITLOCK.
  - Otherwise `keyReset` goes to WAITLOCK.
  - Otherwise `modelS` != `model` goes to DRAIN.
  - Otherwise stay in RUN.
- DRAIN:
  - Counter clears on entry and counts DRAIN cycles; after DRAIN cycles, go to SWITCH.
  - Lock loss, `keyReset` and `modelReq` changes are all ignored in DRAIN.
- SWITCH: lasts one cycle; `model` <= ~`model`; go to WAITLOCK with the counter cleared.
- If `modelReq` reverts during DRAIN, the switch still happens. RUN later detects the mismatch and switches back.
- `rstOut` = 1 in every state except RUN. It is registered and changes on the same edge the state register enters or leaves RUN.
- Divider:
  - `div` is held at 0 outside RUN and increments each RUN cycle, wrapping 15 -> 0.
  - `ce7M0` = RUN && `div`[2:0] == 7.
  - `ce3M5` = RUN && `div` == 15.
  - Both strobes are registered and never asserted while `rstOut` = 1.
- Reset values: state WAITLOCK, `model` 0, `rstOut` 1, `ce7M0` 0, `ce3M5` 0, all counters and synchronizers 0.

## Timing

- Lock to run: `locked` rising at edge t gives `lockedS` = 1 at t+2. `rstOut` falls at edge t+2+HOLD.
- First strobes after leaving reset:
  - `ce7M0` first high on the 8th RUN cycle, then every 8.
  - `ce3M5` first high on the 16th RUN cycle, then every 16.
  - `ce3M5` always coincides with a `ce7M0`.
- Lock loss: `locked` falling at edge t gives `rstOut` high at t+3. Strobes stop the same edge.
- Model switch: `modelReq` change at edge t gives `rstOut` high at t+3 (DRAIN entered). `model` toggles at t+3+DRAIN. Reset releases HOLD cycles later, provided `lockedS` stays high.
- `keyReset` in RUN: `rstOut` high on the next edge, low HOLD+1 edges later.
- Async `reset` forces reset values immediately, mid-operation included. After deassertion, sequencing restarts from WAITLOCK.

## Test plan

- Power-up (HOLD=8, DRAIN=4): `locked`=1 from start, release `reset` at edge 0. Required: `rstOut`=1 until edge 10, `ce7M0` at RUN cycles 8, 16, 24, `ce3M5` at cycle 16 only.
- Lock glitch: drop `locked` for 3 cycles mid-WAITLOCK. Required: counter restarts, `rstOut` stays high a further 8 cycles after `lockedS` returns.
- Model switch: toggle `modelReq` in RUN. Required:
  - `rstOut` rises 3 edges later.
  - `model` flips 4 edges after that.
  - `rstOut` falls 9 edges after the flip (SWITCH + HOLD).
  - No strobe while `rstOut`=1.
- Simultaneous: `keyReset` and lock loss on the same RUN cycle. Required: WAITLOCK taken once, no extra `model` change.
- Revert: `modelReq` toggled and toggled back within DRAIN. Required: `model` flips, then after reset release flips back via a second DRAIN, ending equal to `modelReq`.
- Async `reset` asserted during DRAIN. Required: `model`=0, `rstOut`=1, no strobes, state WAITLOCK on the same cycle.
